alu_retire_stage: RTL

- Stage directly downstream of the 20-bit ALU.
- Accepts each completed ALU operation: opcode, destination, 20-bit result, zero/carry flags, jump target.
- Buffers entries and retires them in order: updates the status register (Z, C, S, T), writes results back to the register file, and resolves program-flow ops (JMP/JZ/JS/JZS/LDSR/XORSR/TRAP/NOP) into PC redirects.

---
 rtl/alu_pkg.sv | 78 +++++++
 rtl/retire_fifo.sv | 71 +++++++
 rtl/alu_retire_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU retire stage.
//   op_e        : 5-bit opcode encoding shared with the upstream ALU
//   FLAG_*      : bit positions inside the 4-bit status word {T,S,C,Z}
//   state_e     : retire-stage run/trap state
//   decode_op   : maps a raw opcode to op_e; unknown encodings become NOP
//   flag_mask   : which of Z/C/S an opcode updates when it retires
//   writes_back : whether an opcode writes its result to the register file
package alu_pkg;

    localparam int OP_W   = 5;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_T = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 5'd0,
        OP_TRAP  = 5'd1,
        OP_JMP   = 5'd2,
        OP_JZ    = 5'd3,
        OP_JS    = 5'd4,
        OP_JZS   = 5'd5,
        OP_LDSR  = 5'd6,
        OP_XORSR = 5'd7,
        OP_NOT   = 5'd8,
        OP_AND   = 5'd9,
        OP_OR    = 5'd10,
        OP_XOR   = 5'd11,
        OP_SHR   = 5'd12,
        OP_SHL   = 5'd13,
        OP_ROR   = 5'd14,
        OP_ROL   = 5'd15,
        OP_INC   = 5'd16,
        OP_SUB   = 5'd17,
        OP_EQ    = 5'd18
    } op_e;

    typedef enum logic {
        STATE_RUN  = 1'b0,
        STATE_TRAP = 1'b1
    } state_e;

    typedef struct packed {
        logic z;
        logic c;
        logic s;
    } flag_mask_t;

    function automatic op_e decode_op(input logic [OP_W-1:0] raw);
        op_e op;
        if (raw <= OP_EQ) op = op_e'(raw);
        else              op = OP_NOP;
        return op;
    endfunction

    function automatic flag_mask_t flag_mask(input op_e op);
        flag_mask_t m;
        case (op)
            OP_NOT, OP_AND, OP_OR, OP_XOR, OP_EQ: m = '{z: 1'b1, c: 1'b0, s: 1'b0};
            OP_SHR, OP_SHL, OP_INC:               m = '{z: 1'b1, c: 1'b1, s: 1'b0};
            OP_SUB:                               m = '{z: 1'b1, c: 1'b1, s: 1'b1};
            default:                              m = '{z: 1'b0, c: 1'b0, s: 1'b0};
        endcase
        return m;
    endfunction

    function automatic logic writes_back(input op_e op);
        logic wb;
        case (op)
            OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_INC, OP_SUB: wb = 1'b1;
            default:                        wb = 1'b0;
        endcase
        return wb;
    endfunction

endpackage

// File: rtl/retire_fifo.sv
// DEPTH-entry register FIFO holding ALU results awaiting retirement.
//   push/push_data : write an entry (caller guarantees !full or a same-cycle pop)
//   pop            : discard the head entry (caller guarantees !empty)
//   flush          : empty the FIFO; overrides a same-cycle push and pop
//   head_data      : current head entry, straight from storage
//   full/empty     : occupancy status
module retire_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d                = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignment; combinational next-state uses blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q[AW-1:0]];
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/alu_retire_stage.sv
// In-order retire stage directly after the 20-bit ALU.
//   in_*            : completed ALU operation, valid/ready handshake
//   wb_*            : register-file writeback, valid/ready handshake
//   redirect_*      : one-cycle PC redirect for taken jumps
//   status          : {T,S,C,Z}
//   trap_active     : stage halted after a TRAP; trap_clear resumes
// Results use the ALU's MSB-first bit numbering, so the sign ("bit 0") is
// res[WIDTH-1] here, and the LDSR/XORSR source field is res[WIDTH-2 -: 3].
module alu_retire_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2,
    parameter int RAW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [RAW-1:0]   in_dst,
    input  logic [WIDTH-1:0] in_res,
    input  logic             in_zero,
    input  logic             in_carry,
    input  logic [WIDTH-1:0] in_target,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [RAW-1:0]   wb_dst,
    output logic [WIDTH-1:0] wb_data,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [3:0]       status,
    output logic             trap_active,
    input  logic             trap_clear
);

    localparam int EW = OP_W + RAW + WIDTH + 2 + WIDTH;

    logic [EW-1:0]    push_data, head_data;
    logic             fifo_full, fifo_empty;
    logic             push, pop, flush;

    logic [OP_W-1:0]  head_op_raw;
    logic [RAW-1:0]   head_dst;
    logic [WIDTH-1:0] head_res, head_target;
    logic             head_zero, head_carry;

    op_e              head_op;
    flag_mask_t       head_mask;
    logic             head_is_wb, running, retire, jump_cond, take_jump, trap_hit;

    state_e           state_q, state_d;
    logic [3:0]       status_q, status_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic             ready_en_q, ready_en_d;

    assign push_data = {in_op, in_dst, in_res, in_zero, in_carry, in_target};
    assign {head_op_raw, head_dst, head_res, head_zero, head_carry, head_target} = head_data;

    retire_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Handshake and retire decision.
    always_comb begin
        head_op    = decode_op(head_op_raw);
        head_mask  = flag_mask(head_op);
        head_is_wb = writes_back(head_op);
        running    = (state_q == STATE_RUN);

        wb_valid   = running && !fifo_empty && head_is_wb;
        retire     = running && !fifo_empty && (!head_is_wb || wb_ready);

        // Status register already reflects every older retired entry.
        case (head_op)
            OP_JMP:  jump_cond = 1'b1;
            OP_JZ:   jump_cond = status_q[FLAG_Z];
            OP_JS:   jump_cond = status_q[FLAG_S];
            OP_JZS:  jump_cond = status_q[FLAG_Z] | status_q[FLAG_S];
            default: jump_cond = 1'b0;
        endcase
        take_jump = retire && jump_cond;
        trap_hit  = retire && (head_op == OP_TRAP);

        pop   = retire;
        flush = take_jump || trap_hit;   // also drops an entry pushed on this edge

        // A full buffer still accepts when the head leaves in the same cycle.
        in_ready = ready_en_q && running && !redirect_valid_q && (!fifo_full || retire);
        push     = in_valid && in_ready;
    end

    // Status, run/trap state and redirect next-state.
    always_comb begin
        status_d         = status_q;
        state_d          = state_q;
        redirect_valid_d = take_jump;
        redirect_pc_d    = take_jump ? head_target : redirect_pc_q;
        ready_en_d       = 1'b1;

        if (retire) begin
            if (head_mask.z) status_d[FLAG_Z] = head_zero;
            if (head_mask.c) status_d[FLAG_C] = head_carry;
            if (head_mask.s) status_d[FLAG_S] = head_res[WIDTH-1];
            if (head_op == OP_LDSR)  status_d[FLAG_S:FLAG_Z] = head_res[WIDTH-2 -: 3];
            if (head_op == OP_XORSR) status_d[FLAG_S:FLAG_Z] = status_q[FLAG_S:FLAG_Z] ^ head_res[WIDTH-2 -: 3];
            if (trap_hit) begin
                status_d[FLAG_T] = 1'b1;
                state_d          = STATE_TRAP;
            end
        end

        // trap_clear only matters once halted, so a TRAP retiring alongside it wins.
        if (state_q == STATE_TRAP && trap_clear) begin
            status_d[FLAG_T] = 1'b0;
            state_d          = STATE_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= STATE_RUN;
            status_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            ready_en_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            status_q         <= status_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            ready_en_q       <= ready_en_d;
        end
    end

    assign wb_dst         = head_dst;
    assign wb_data        = head_res;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign status         = status_q;
    assign trap_active    = (state_q == STATE_TRAP);

endmodule
